// File: rtl/core_uart_rx.sv
// UART receiver: 8N1 framing, 2-flop line synchronizer, mid-bit sampling,
// and a small receive FIFO with valid/ready drain.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for a high-to-low edge on the line
// S_START | counting half a bit, confirming the start bit
// S_DATA  | sampling 8 data bits, LSB first
// S_STOP  | sampling the stop bit
module core_uart_rx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rxd,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
  output logic                          frame_err_o,
  output logic                          overrun_o
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 2;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  if (DIV < 4) begin : g_div_check
    $error("core_uart_rx: CLK_FREQ_HZ/BAUD must be at least 4");
  end

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("core_uart_rx: FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [1:0]      sync_q;
  logic [1:0]      sync_fill_q;
  logic            prev_hi_q;
  logic            line;
  logic            falling;

  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shreg_q;
  logic            tick;

  logic            load_half;
  logic            sample;
  logic            shift_en;
  logic            push_set;
  logic            ferr_set;

  logic            push_q;
  logic [7:0]      push_data_q;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            full;
  logic            pop;
  logic            wr_en;

  // prev_hi_q only counts a high level once the synchronizer holds real
  // line samples, so the reset value of the flops never forms an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q      <= 2'b11;
      sync_fill_q <= 2'b00;
      prev_hi_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd};
      sync_fill_q <= {sync_fill_q[0], 1'b1};
      prev_hi_q   <= line & sync_fill_q[1];
    end
  end

  assign line    = sync_q[1];
  assign falling = prev_hi_q & ~line;
  assign tick    = (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (falling) state_d = S_START;
      S_START: if (tick) state_d = line ? S_IDLE : S_DATA;
      S_DATA:  if (tick && (bit_idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    sample    = 1'b0;
    shift_en  = 1'b0;
    push_set  = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      S_IDLE:  load_half = falling;
      S_START: sample    = tick;
      S_DATA: begin
        sample   = tick;
        shift_en = tick;
      end
      S_STOP: begin
        sample   = tick;
        push_set = tick & line;
        ferr_set = tick & ~line;
      end
      default: ;
    endcase
  end

  // The bit timer reloads at every sample point so error never accumulates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
      frame_err_o <= 1'b0;
    end else begin
      if (load_half) begin
        cnt_q <= HALF_M1;
      end else if (sample) begin
        cnt_q <= DIV_M1;
      end else if (state_q != S_IDLE) begin
        cnt_q <= cnt_q - CW'(1);
      end

      if (load_half) begin
        bit_idx_q <= 3'd0;
      end else if (shift_en) begin
        bit_idx_q <= bit_idx_q + 3'd1;
      end

      if (shift_en) begin
        shreg_q <= {line, shreg_q[7:1]};
      end

      push_q      <= push_set;
      frame_err_o <= ferr_set;
      if (push_set) begin
        push_data_q <= shreg_q;
      end
    end
  end

  assign full  = (count_q == DEPTH_C);
  assign pop   = rx_valid_o & rx_ready_i;
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign wr_en = push_q & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= push_data_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      overrun_o <= push_q & full & ~pop;
    end
  end

  assign rx_valid_o = (count_q != '0);
  assign rx_count_o = count_q;
  assign rx_data_o  = rx_valid_o ? mem[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_core_uart_rx.sv
// Scoreboard bench for core_uart_rx at DIV=16: senders queue expected bytes,
// a negedge monitor checks every popped byte and counts error pulses.
module tb_core_uart_rx;

  localparam int DIV = 16;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rxd;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [2:0] rx_count_o;
  logic       frame_err_o;
  logic       overrun_o;

  int         n_cmp = 0;
  int         n_err = 0;
  int         ferr_seen = 0;
  int         ovr_seen = 0;
  int         exp_ferr = 0;
  int         exp_ovr = 0;
  int         cyc;
  logic [7:0] exp_q [$];

  core_uart_rx #(
    .CLK_FREQ_HZ (1_600_000),
    .BAUD        (100_000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rxd         (rxd),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .rx_count_o  (rx_count_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(DIV);
    end
    rxd = stop_bit;
    wait_cycles(DIV);
  endtask

  task automatic send_good(input logic [7:0] b, input logic keep);
    if (keep) exp_q.push_back(b);
    send_byte(b, 1'b1);
  endtask

  task automatic pop_one();
    int n;
    n = 0;
    while (!rx_valid_o && n < 50) begin
      wait_cycles(1);
      n++;
    end
    chk("pop_valid", int'(rx_valid_o), 1);
    rx_ready_i = 1'b1;
    wait_cycles(1);
    rx_ready_i = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pop: got 0x%02h, expected no byte", rx_data_o);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("pop_data", int'(rx_data_o), int'(e));
        end
      end
      if (frame_err_o) ferr_seen++;
      if (overrun_o)   ovr_seen++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rxd        = 1'b1;
    rx_ready_i = 1'b0;
    rst_i      = 1'b1;
    wait_cycles(3);
    chk("rst_count", int'(rx_count_o), 0);
    chk("rst_valid", int'(rx_valid_o), 0);
    chk("rst_data", int'(rx_data_o), 0);
    chk("rst_ferr", int'(frame_err_o), 0);
    chk("rst_ovr", int'(overrun_o), 0);
    rst_i = 1'b0;
    wait_cycles(5);

    // single byte, latency from the rxd falling edge to rx_valid_o
    cyc = 0;
    fork
      send_good(8'h55, 1'b1);
      begin
        while (!rx_valid_o && cyc < 400) begin
          @(posedge clk_i);
          #1;
          cyc++;
        end
      end
    join
    chk("latency_55", cyc, 156);
    chk("count_55", int'(rx_count_o), 1);
    chk("data_55", int'(rx_data_o), 8'h55);
    pop_one();
    chk("count_55_after_pop", int'(rx_count_o), 0);

    // back-to-back frames
    send_good(8'hA3, 1'b1);
    send_good(8'h0F, 1'b1);
    wait_cycles(4);
    chk("count_b2b", int'(rx_count_o), 2);
    pop_one();
    chk("count_b2b_pop1", int'(rx_count_o), 1);
    pop_one();
    chk("count_b2b_pop2", int'(rx_count_o), 0);
    chk("valid_b2b_empty", int'(rx_valid_o), 0);

    // false start glitch, then a good byte soon after
    rxd = 1'b0;
    wait_cycles(4);
    rxd = 1'b1;
    wait_cycles(12);
    send_good(8'h5A, 1'b1);
    wait_cycles(4);
    chk("count_after_glitch", int'(rx_count_o), 1);
    chk("ferr_after_glitch", ferr_seen, exp_ferr);
    pop_one();

    // framing error, then recovery
    send_byte(8'h3C, 1'b0);
    rxd = 1'b1;
    exp_ferr++;
    wait_cycles(16);
    chk("ferr_pulse", ferr_seen, exp_ferr);
    chk("count_ferr", int'(rx_count_o), 0);
    send_good(8'h81, 1'b1);
    wait_cycles(4);
    chk("count_81", int'(rx_count_o), 1);
    pop_one();

    // overrun on the fifth byte
    for (int v = 1; v <= 5; v++) begin
      send_good(8'(v), v <= 4);
    end
    exp_ovr++;
    wait_cycles(4);
    chk("ovr_pulse", ovr_seen, exp_ovr);
    chk("count_full", int'(rx_count_o), 4);
    repeat (4) pop_one();
    chk("count_drained", int'(rx_count_o), 0);
    chk("valid_drained", int'(rx_valid_o), 0);

    // full FIFO with a pop in the push cycle
    for (int v = 1; v <= 4; v++) begin
      send_good(8'(v), 1'b1);
    end
    chk("count_full2", int'(rx_count_o), 4);
    exp_q.push_back(8'h05);
    fork
      send_byte(8'h05, 1'b1);
      begin
        repeat (155) @(posedge clk_i);
        #1;
        rx_ready_i = 1'b1;
        wait_cycles(1);
        rx_ready_i = 1'b0;
      end
    join
    wait_cycles(4);
    chk("count_push_pop_full", int'(rx_count_o), 4);
    chk("no_ovr_push_pop", ovr_seen, exp_ovr);
    repeat (4) pop_one();
    chk("count_drained2", int'(rx_count_o), 0);

    // reset in the middle of a frame
    fork
      send_byte(8'h00, 1'b1);
      begin
        wait_cycles(80);
        rst_i = 1'b1;
        wait_cycles(2);
        rst_i = 1'b0;
      end
    join
    wait_cycles(20);
    chk("count_mid_reset", int'(rx_count_o), 0);
    chk("ferr_mid_reset", ferr_seen, exp_ferr);

    // line held low through reset release
    rst_i = 1'b1;
    rxd   = 1'b0;
    wait_cycles(3);
    rst_i = 1'b0;
    wait_cycles(200);
    chk("count_low_line", int'(rx_count_o), 0);
    chk("ferr_low_line", ferr_seen, exp_ferr);
    rxd = 1'b1;
    wait_cycles(20);
    send_good(8'hC6, 1'b1);
    wait_cycles(4);
    chk("count_C6", int'(rx_count_o), 1);
    pop_one();

    wait_cycles(10);
    chk("queue_empty", exp_q.size(), 0);
    chk("ovr_total", ovr_seen, exp_ovr);
    chk("ferr_total", ferr_seen, exp_ferr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
